md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit for the EX stage, beside the ALU. Owns the HI/LO registers,
//   sequences MULT/MULTU (fixed latency) and DIV/DIVU (fixed latency) and executes MTHI/MTLO.
//   Raises BUSY while an operation is in flight. Drives MD_STALL so the hazard unit freezes any
//   MDU-using instruction in D until HI/LO are final.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   reset      in   1   synchronous, active-high
//   A          in   32  rs operand (forwarded)
//   B          in   32  rt operand (forwarded)
//   MD_OP      in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved(=NONE)
//   START      in   1   EX holds an MDU op this cycle and EX is not stalled
//   MD_USE_D   in   1   instruction in D is mult/div/mfhi/mflo/mthi/mtlo
//   HI         out  32  HI register
//   LO         out  32  LO register
//   BUSY       out  1   operation in flight
//   MD_STALL   out  1   combinational: MD_USE_D & (BUSY | (START & MD_OP in 1..4))
// BEHAVIOUR
//   Reset: HI=0, LO=0, BUSY=0, counter=0, state IDLE, pending result discarded.
//   Reset mid-operation wins over everything: next cycle IDLE, HI/LO=0, nothing retires.
//   States: IDLE, RUN. Down-counter cnt, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
//   IDLE, START, op 1..4 at edge t: capture 64-bit result into pend_hi/pend_lo, cnt=N
//     (N=MULT_CYCLES or DIV_CYCLES), go RUN. BUSY=1 in cycles t+1..t+N.
//   RUN: cnt decrements each cycle; at edge ending cycle where cnt==1: HI<=pend_hi,
//     LO<=pend_lo, go IDLE. New HI/LO and BUSY=0 visible from cycle t+N+1.
//   IDLE, START, MTHI: HI<=A next edge; MTLO: LO<=A next edge; BUSY stays 0.
//   START with NONE/reserved: no effect. START while RUN: ignored; sim assertion error.
//   MULT: {HI,LO}=$signed(A)*$signed(B); MULTU: unsigned 64-bit product.
//   DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend (A).
//     0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
//   DIVU: LO=A/B, HI=A%B, unsigned.
//   B==0 on DIV/DIVU: full busy sequence runs, HI/LO unchanged at retire.
//   HI/LO read directly (MFHI/MFLO mux is outside); never expose partial results.
// STRUCTURE
//   md_pkg: MD_OP encodings (MD_NONE..MD_MTLO), state encoding, default latencies.
//   Sub-module md_calc: combinational 32x32 signed/unsigned mul and div/rem incl. div-by-zero
//     and overflow flags; md_unit holds FSM, counter, pend/HI/LO registers, stall logic.
// TESTING
//   reset, then MULT A=0xFFFF_FFFE B=3 START 1 cycle -> BUSY 5 cycles, then HI=0xFFFF_FFFF LO=0xFFFF_FFFA.
//   MULTU A=0xFFFF_FFFF B=2 -> after 5 busy cycles HI=1 LO=0xFFFF_FFFE.
//   DIV A=-7 B=2 -> BUSY 10 cycles, LO=0xFFFF_FFFD HI=0xFFFF_FFFF; DIVU A=7 B=0 -> HI/LO unchanged.
//   MTHI A=0x1234 then MTLO A=0x5678 back-to-back -> BUSY never 1, HI=0x1234 LO=0x5678 next edges.
//   MULT running, MD_USE_D=1 -> MD_STALL=1 in start cycle and all busy cycles, 0 on first IDLE cycle.
//   DIV in flight, reset at busy cycle 4 -> next cycle BUSY=0 HI=LO=0, no later retire.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and default latencies for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_zero;
        logic        ovf;
    } md_res_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and divide/remainder, signed and unsigned.
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      op,
    output md_res_t     res
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] sa;
    logic signed [31:0] sdiv;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] udiv;
    logic               dz;
    logic               ovf;

    always_comb begin
        sa    = a;
        sa64  = {{32{a[31]}}, a};
        sb64  = {{32{b[31]}}, b};
        sprod = sa64 * sb64;
        uprod = {32'd0, a} * {32'd0, b};
        dz    = (b == 32'd0);
        ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Safe divisors keep the dividers free of X on the special cases.
        sdiv  = (dz || ovf) ? 32'sd1 : b;
        udiv  = dz ? 32'd1 : b;
        sq    = sa / sdiv;
        sr    = sa % sdiv;
        res   = '0;
        unique case (1'b1)
            op == MD_MULT: begin
                {res.hi, res.lo} = sprod;
            end
            op == MD_MULTU: begin
                {res.hi, res.lo} = uprod;
            end
            op == MD_DIV: begin
                res.lo       = ovf ? 32'h8000_0000 : sq;
                res.hi       = ovf ? 32'd0 : sr;
                res.div_zero = dz;
                res.ovf      = ovf;
            end
            op == MD_DIVU: begin
                res.lo       = a / udiv;
                res.hi       = a % udiv;
                res.div_zero = dz;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: HI/LO owner, fixed-latency sequencer,
// and the stall request that holds MDU users in D.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MD_OP,
    input  logic        START,
    input  logic        MD_USE_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        MD_STALL
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state;
    md_state_e   state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_keep;
    logic        cap;
    logic        ret;
    logic        wr_hi;
    logic        wr_lo;
    logic        is_mul;
    logic        is_div;
    md_op_e      op;
    md_res_t     res;
    logic        calc_unused;

    assign op     = md_op_e'(MD_OP);
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);

    md_calc u_calc (
        .a   (A),
        .b   (B),
        .op  (op),
        .res (res)
    );

    assign calc_unused = res.ovf;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        ret     = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    unique case (1'b1)
                        is_mul: begin
                            cap     = 1'b1;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = ST_RUN;
                        end
                        is_div: begin
                            cap     = 1'b1;
                            cnt_n   = CW'(DIV_CYCLES);
                            state_n = ST_RUN;
                        end
                        op == MD_MTHI: wr_hi = 1'b1;
                        op == MD_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    ret     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            HI        <= '0;
            LO        <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_keep <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (cap) begin
                pend_hi   <= res.hi;
                pend_lo   <= res.lo;
                pend_keep <= res.div_zero;
            end
            // Divide-by-zero runs the full sequence but leaves HI/LO alone.
            if (ret && !pend_keep) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
        end
    end

    assign BUSY     = (state == ST_RUN);
    assign MD_STALL = MD_USE_D & (BUSY | (START & (is_mul | is_div)));

    assert property (@(posedge clk) disable iff (reset)
        !(START && state == ST_RUN))
        else $error("md_unit: START while operation in flight");

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with an expected-result scoreboard.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MD_OP;
    logic        START;
    logic        MD_USE_D;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        MD_STALL;

    int          n_pass;
    int          n_chk;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [63:0] sb[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .MD_OP    (MD_OP),
        .START    (START),
        .MD_USE_D (MD_USE_D),
        .HI       (HI),
        .LO       (LO),
        .BUSY     (BUSY),
        .MD_STALL (MD_STALL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic use_d,
                          input logic [63:0] exp);
        int          cyc;
        logic        md;
        logic        bad_st;
        logic        bad_hl;
        logic [63:0] e;
        md     = (op >= 3'd1) && (op <= 3'd4);
        bad_st = 1'b0;
        bad_hl = 1'b0;
        sb.push_back(exp);
        START    = 1'b1;
        MD_OP    = op;
        A        = a;
        B        = b;
        MD_USE_D = use_d;
        #1;
        chk({nm, "_stall_start"}, 64'(MD_STALL), 64'(use_d & md));
        chk({nm, "_busy_start"}, 64'(BUSY), 64'(0));
        @(negedge clk);
        START = 1'b0;
        MD_OP = 3'd0;
        A     = $urandom;
        B     = $urandom;
        cyc   = 0;
        while (BUSY === 1'b1 && cyc < 64) begin
            cyc++;
            if (MD_STALL !== use_d) bad_st = 1'b1;
            if (HI !== hi_m || LO !== lo_m) bad_hl = 1'b1;
            @(negedge clk);
        end
        chk({nm, "_busy_len"}, 64'(cyc), 64'(n));
        chk({nm, "_stall_busy"}, 64'(bad_st), 64'(0));
        chk({nm, "_no_partial"}, 64'(bad_hl), 64'(0));
        #1;
        chk({nm, "_stall_idle"}, 64'(MD_STALL), 64'(0));
        e = sb.pop_front();
        chk({nm, "_hi"}, 64'(HI), 64'(e[63:32]));
        chk({nm, "_lo"}, 64'(LO), 64'(e[31:0]));
        hi_m = e[63:32];
        lo_m = e[31:0];
    endtask

    initial begin
        logic bad;
        n_pass   = 0;
        n_chk    = 0;
        hi_m     = 32'd0;
        lo_m     = 32'd0;
        reset    = 1'b1;
        A        = 32'd0;
        B        = 32'd0;
        MD_OP    = 3'd0;
        START    = 1'b0;
        MD_USE_D = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(HI), 64'(0));
        chk("rst_lo", 64'(LO), 64'(0));
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_stall", 64'(MD_STALL), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b1,
               64'h0000_0001_FFFF_FFFE);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_z", 3'd4, 32'd7, 32'd0, 10, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 1'b1,
               64'h0000_0001_FFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b1,
               64'h0000_0000_8000_0000);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 1'b0,
               64'h0000_0002_0000_000E);
        run_op("mult_big", 3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 1'b0,
               64'h3FFF_FFFF_0000_0001);
        run_op("mthi", 3'd5, 32'h0000_1234, 32'd9, 0, 1'b1,
               64'h0000_1234_0000_0001);
        run_op("mtlo", 3'd6, 32'h0000_5678, 32'd9, 0, 1'b1,
               64'h0000_1234_0000_5678);
        run_op("rsvd", 3'd7, 32'hDEAD_BEEF, 32'd1, 0, 1'b1,
               64'h0000_1234_0000_5678);
        run_op("div_z", 3'd3, 32'd0, 32'd0, 10, 1'b1,
               64'h0000_1234_0000_5678);

        START = 1'b1;
        MD_OP = 3'd3;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        START = 1'b0;
        MD_OP = 3'd0;
        bad   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (BUSY !== 1'b1) bad = 1'b1;
            if (i < 4) @(negedge clk);
        end
        chk("rstmid_busy_pre", 64'(bad), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", 64'(BUSY), 64'(0));
        chk("rstmid_hi", 64'(HI), 64'(0));
        chk("rstmid_lo", 64'(LO), 64'(0));
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (BUSY !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
                bad = 1'b1;
        end
        chk("rstmid_no_retire", 64'(bad), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
